memoria_instrucciones_sync: RTL and testbench
=============================================

Name: memoria_instrucciones_sync

Overview:
Parametrised, synchronous-read instruction memory for the fetch stage. Byte-addressed storage, with words assembled from consecutive bytes. It adds three things:
- a valid/ready fetch port with 1-cycle latency and backpressure;
- a byte-wide program-load port;
- alignment and range error detection.

It sits between the PC/fetch logic and the decode stage and replaces the combinational, hardcoded instruction ROM.

Parameters:
ANCHO_DIR, 32, address width in bits (byte address).
PROFUNDIDAD, 256, storage depth in bytes; must be a multiple of BYTES_PAL.
ANCHO_PAL, 32, instruction word width in bits; multiple of 8. BYTES_PAL = ANCHO_PAL/8.
BIG_ENDIAN, 1, 1: mem[dir] is the MSB of the word; 0: mem[dir] is the LSB.
ARCHIVO_INIT, "", hex file loaded with $readmemh at elaboration; empty means no preload.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  block can accept a request this cycle
req_dir  in  ANCHO_DIR  fetch byte address
resp_valid  out  1  response word valid
resp_ready  in  1  consumer accepts the response
resp_dato  out  ANCHO_PAL  fetched instruction word
resp_error  out  1  fetch faulted (misaligned or out of range)
carga_en  in  1  program-load byte write enable
carga_dir  in  ANCHO_DIR  program-load byte address
carga_byte  in  8  program-load data
cont_fetch  out  32  number of fetches accepted since reset

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: resp_valid=0, resp_dato=0, resp_error=0, cont_fetch=0. Memory contents are not cleared by reset.
- req_ready = !resp_valid || resp_ready. This is combinational; it is the only combinational path from resp_ready.
- Request accepted on a rising edge when req_valid && req_ready && !rst. The response is registered on that edge, so resp_valid=1 in the next cycle.
- Throughput: 1 word/cycle when resp_ready is held at 1.
- Response hold: while resp_valid && !resp_ready, resp_dato and resp_error stay stable and no new request is accepted.
- Response retire: if resp_valid && resp_ready and no new request is accepted, resp_valid goes to 0 next cycle. resp_dato keeps its last value.
- Error condition: (req_dir mod BYTES_PAL) != 0, or req_dir + BYTES_PAL - 1 >= PROFUNDIDAD (compare at ANCHO_DIR+1 bits so overflow is detected). On error: resp_error=1, resp_dato=0, and no memory read happens.
- Word assembly, BIG_ENDIAN=1: {mem[d], mem[d+1], …, mem[d+BYTES_PAL-1]}. BIG_ENDIAN=0: byte order reversed.
- Load port: when carga_en=1, mem[carga_dir] <= carga_byte at the edge. A write with carga_dir >= PROFUNDIDAD is ignored silently.
- Load during reset: a load asserted while rst=1 is still performed (memory is not under reset).
- Simultaneous load and fetch of an overlapping address: the fetch returns the old byte (read-before-write). The new byte is visible to fetches accepted from the next cycle onward.
- cont_fetch increments by 1 per accepted request, including errored ones, and wraps at 2^32.
- Reset mid-operation: a pending response is dropped. resp_valid=0 in the cycle after the rst edge; req_ready=1 from that cycle.

Decomposition:
- Shared package: BYTES_PAL derivation, the endian-mode constants, and the fetch error-code encoding (reserved for a future multi-bit error).
- One natural sub-module, ensamblador_palabra: combinational byte-to-word packer parametrised by BYTES_PAL and BIG_ENDIAN. It is reused by the data memory.
- The handshake register and error check stay in the top module.

Test Plan:
1. Load bytes 01,4A,18,20 at addresses 0–3 (BIG_ENDIAN=1), then fetch dir 0 with resp_ready=1 → next cycle resp_valid=1, resp_dato=0x014A1820, resp_error=0, cont_fetch=1.
2. Same load with BIG_ENDIAN=0, fetch dir 0 → resp_dato=0x20184A01.
3. Fetch dir 2 → resp_error=1, resp_dato=0. Fetch dir 252 → OK. Fetch dir 256 → resp_error=1. Fetch dir 0xFFFFFFFC → resp_error=1 (no wrap). cont_fetch counts all four fetches.
4. Backpressure: fetch dir 0, then hold resp_ready=0 for 3 cycles with req_valid=1 at dir 4 → resp_dato holds 0x014A1820 and req_ready=0. Raise resp_ready → the dir 4 word appears the following cycle.
5. Back-to-back fetches of 0, 4, 8 with resp_ready=1 → three consecutive valid responses, no bubbles. In the same cycle as the fetch of 4, carga_en writes 0xFF at address 4 → the response carries the old byte; a re-fetch of 4 carries 0xFF in the MSB.
6. Assert rst while resp_valid=1 and resp_ready=0 → next cycle resp_valid=0, resp_dato=0, cont_fetch=0, req_ready=1. Memory bytes 0–3 are still 01,4A,18,20.

Source files
------------

// File: rtl/memoria_instrucciones_sync_pkg.sv
// Shared definitions for the instruction memory and its byte-to-word packer:
// word-size derivation, byte-order modes and fetch error codes.
package memoria_instrucciones_sync_pkg;

   function automatic int calc_bytes_pal(input int ancho_pal);
      return ancho_pal / 8;
   endfunction

   localparam int ENDIAN_PEQUENO = 0;
   localparam int ENDIAN_GRANDE  = 1;

   // Only "any error" reaches the port today; the code keeps the cause for later.
   typedef enum logic [1:0] {
      ERR_NINGUNO    = 2'd0,
      ERR_ALINEACION = 2'd1,
      ERR_RANGO      = 2'd2
   } error_fetch_t;

endpackage

// File: rtl/memoria_instrucciones_sync_ensamblador_palabra.sv
// Combinational packer: byte i of bytes_in is the byte at address base+i,
// placed in the word according to the byte order.
module ensamblador_palabra
   import memoria_instrucciones_sync_pkg::*;
#(
   parameter int BYTES_PAL  = 4,
   parameter int BIG_ENDIAN = ENDIAN_GRANDE
) (
   input  logic [8*BYTES_PAL-1:0] bytes_in,
   output logic [8*BYTES_PAL-1:0] palabra
);

   for (genvar i = 0; i < BYTES_PAL; i++) begin : g_byte
      if (BIG_ENDIAN == ENDIAN_GRANDE) begin : g_grande
         assign palabra[8*(BYTES_PAL-1-i) +: 8] = bytes_in[8*i +: 8];
      end else begin : g_pequeno
         assign palabra[8*i +: 8] = bytes_in[8*i +: 8];
      end
   end

endmodule

// File: rtl/memoria_instrucciones_sync.sv
// Byte-addressed instruction memory with a registered valid/ready fetch port,
// a byte-wide program-load port and alignment/range fault detection.
module memoria_instrucciones_sync
   import memoria_instrucciones_sync_pkg::*;
#(
   parameter int    ANCHO_DIR    = 32,
   parameter int    PROFUNDIDAD  = 256,
   parameter int    ANCHO_PAL    = 32,
   parameter int    BIG_ENDIAN   = ENDIAN_GRANDE,
   parameter string ARCHIVO_INIT = ""
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ANCHO_DIR-1:0] req_dir,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ANCHO_PAL-1:0] resp_dato,
   output logic                 resp_error,
   input  logic                 carga_en,
   input  logic [ANCHO_DIR-1:0] carga_dir,
   input  logic [7:0]           carga_byte,
   output logic [31:0]          cont_fetch
);

   localparam int BYTES_PAL = calc_bytes_pal(ANCHO_PAL);
   localparam int AW        = $clog2(PROFUNDIDAD);

   logic [7:0]           mem [PROFUNDIDAD];
   logic [AW-1:0]        base;
   logic [ANCHO_PAL-1:0] bytes_leidos;
   logic [ANCHO_PAL-1:0] palabra;
   logic [ANCHO_DIR:0]   dir_fin;
   error_fetch_t         codigo;
   logic                 acepta;

   // Handshake: a request transfers on an edge where req_valid && req_ready;
   // a response transfers where resp_valid && resp_ready. The response
   // register may be refilled in the same cycle it is drained.
   assign req_ready = !resp_valid || resp_ready;
   assign acepta    = req_valid && req_ready;

   // One extra bit so a fetch near the top of the address space cannot wrap.
   assign dir_fin = {1'b0, req_dir} + (ANCHO_DIR+1)'(BYTES_PAL - 1);
   assign base    = req_dir[AW-1:0];

   always_comb begin
      codigo = ERR_NINGUNO;
      if ((req_dir % ANCHO_DIR'(BYTES_PAL)) != '0)
         codigo = ERR_ALINEACION;
      else if (dir_fin >= (ANCHO_DIR+1)'(PROFUNDIDAD))
         codigo = ERR_RANGO;
   end

   always_comb begin
      bytes_leidos = '0;
      for (int i = 0; i < BYTES_PAL; i++)
         bytes_leidos[8*i +: 8] = mem[base + AW'(i)];
   end

   ensamblador_palabra #(
      .BYTES_PAL  (BYTES_PAL),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_ensamblador (
      .bytes_in (bytes_leidos),
      .palabra  (palabra)
   );

   // Not reset; the fetch above samples the old contents on a same-edge write.
   always_ff @(posedge clk) begin
      if (carga_en && (carga_dir < ANCHO_DIR'(PROFUNDIDAD)))
         mem[carga_dir[AW-1:0]] <= carga_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_dato  <= '0;
         resp_error <= 1'b0;
         cont_fetch <= '0;
      end else if (acepta) begin
         resp_valid <= 1'b1;
         resp_error <= (codigo != ERR_NINGUNO);
         resp_dato  <= (codigo != ERR_NINGUNO) ? '0 : palabra;
         cont_fetch <= cont_fetch + 32'd1;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memoria_instrucciones_sync.sv
// Bench for memoria_instrucciones_sync: big- and little-endian instances share
// all stimulus and are checked every cycle against a byte-array model.
module tb_memoria_instrucciones_sync;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_dir;
   logic        resp_ready;
   logic        carga_en;
   logic [31:0] carga_dir;
   logic [7:0]  carga_byte;

   logic        req_ready_be, resp_valid_be, resp_error_be;
   logic [31:0] resp_dato_be, cont_fetch_be;
   logic        req_ready_le, resp_valid_le, resp_error_le;
   logic [31:0] resp_dato_le, cont_fetch_le;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   memoria_instrucciones_sync #(.BIG_ENDIAN(1)) dut_be (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready_be), .req_dir(req_dir),
      .resp_valid(resp_valid_be), .resp_ready(resp_ready),
      .resp_dato(resp_dato_be), .resp_error(resp_error_be),
      .carga_en(carga_en), .carga_dir(carga_dir), .carga_byte(carga_byte),
      .cont_fetch(cont_fetch_be)
   );

   memoria_instrucciones_sync #(.BIG_ENDIAN(0)) dut_le (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready_le), .req_dir(req_dir),
      .resp_valid(resp_valid_le), .resp_ready(resp_ready),
      .resp_dato(resp_dato_le), .resp_error(resp_error_le),
      .carga_en(carga_en), .carga_dir(carga_dir), .carga_byte(carga_byte),
      .cont_fetch(cont_fetch_le)
   );

   // ---------------- model ----------------
   logic [7:0]  m_mem [256];
   logic        m_valid = 1'b0;
   logic        m_error = 1'b0;
   logic [31:0] m_dato_be = '0;
   logic [31:0] m_dato_le = '0;
   logic [31:0] m_cont = '0;
   bit          arrancado = 1'b0;

   function automatic bit fallo_modelo(input logic [31:0] d);
      longint unsigned dl = longint'(d);
      return ((dl % 4) != 0) || ((dl + 3) >= 256);
   endfunction

   function automatic logic [31:0] palabra_modelo(input logic [31:0] d, input bit grande);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) begin
         if (grande) w = (w << 8) | 32'(m_mem[d[7:0] + 8'(i)]);
         else        w = w | (32'(m_mem[d[7:0] + 8'(i)]) << (8 * i));
      end
      return w;
   endfunction

   always @(posedge clk) begin
      arrancado = 1'b1;
      if (rst) begin
         m_valid = 1'b0; m_error = 1'b0; m_dato_be = '0; m_dato_le = '0; m_cont = '0;
      end else if (req_valid && (!m_valid || resp_ready)) begin
         m_valid = 1'b1;
         m_cont  = m_cont + 1;
         m_error = fallo_modelo(req_dir);
         m_dato_be = m_error ? 32'd0 : palabra_modelo(req_dir, 1'b1);
         m_dato_le = m_error ? 32'd0 : palabra_modelo(req_dir, 1'b0);
      end else if (resp_ready) begin
         m_valid = 1'b0;
      end
      // Load applied after the fetch so the fetch sees the old byte.
      if (carga_en && carga_dir < 256) m_mem[carga_dir[7:0]] = carga_byte;
   end

   // ---------------- scoreboard ----------------
   task automatic comparar(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      n_cmp++;
      if (actual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nombre, actual, esperado, $time);
      end
   endtask

   always @(negedge clk) begin
      if (arrancado) begin
         comparar("be.resp_valid", 32'(resp_valid_be), 32'(m_valid));
         comparar("le.resp_valid", 32'(resp_valid_le), 32'(m_valid));
         comparar("be.req_ready",  32'(req_ready_be),  32'(!m_valid || resp_ready));
         comparar("le.req_ready",  32'(req_ready_le),  32'(!m_valid || resp_ready));
         comparar("be.resp_error", 32'(resp_error_be), 32'(m_error));
         comparar("le.resp_error", 32'(resp_error_le), 32'(m_error));
         comparar("be.resp_dato",  resp_dato_be, m_dato_be);
         comparar("le.resp_dato",  resp_dato_le, m_dato_le);
         comparar("be.cont_fetch", cont_fetch_be, m_cont);
         comparar("le.cont_fetch", cont_fetch_le, m_cont);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] d);
      req_valid = 1'b1;
      req_dir   = d;
      ciclo();
      req_valid = 1'b0;
   endtask

   function automatic logic [7:0] patron(input int a);
      return 8'((a * 37 + 5) & 255);
   endfunction

   // ---------------- directed stimulus ----------------
   initial begin
      logic [7:0] prog [4];
      prog[0] = 8'h01; prog[1] = 8'h4A; prog[2] = 8'h18; prog[3] = 8'h20;
      rst = 1'b1; req_valid = 1'b0; req_dir = '0; resp_ready = 1'b1;
      carga_en = 1'b0; carga_dir = '0; carga_byte = '0;

      // Memory is loaded while reset is held: loads are not under reset.
      for (int a = 0; a < 256; a++) begin
         carga_en = 1'b1; carga_dir = 32'(a); carga_byte = patron(a);
         ciclo();
      end
      for (int a = 0; a < 4; a++) begin
         carga_dir = 32'(a); carga_byte = prog[a];
         ciclo();
      end
      carga_dir = 32'd300; carga_byte = 8'hAA;   // out of range: must not alias address 44
      ciclo();
      carga_en = 1'b0;
      rst = 1'b0;
      ciclo();
      comparar("reset.resp_valid", 32'(resp_valid_be), 32'd0);
      comparar("reset.resp_dato",  resp_dato_be, 32'd0);
      comparar("reset.cont_fetch", cont_fetch_be, 32'd0);
      comparar("reset.req_ready",  32'(req_ready_be), 32'd1);

      // Basic fetch, both byte orders
      fetch(32'd0);
      comparar("t1.valid", 32'(resp_valid_be), 32'd1);
      comparar("t1.dato_be", resp_dato_be, 32'h014A1820);
      comparar("t2.dato_le", resp_dato_le, 32'h20184A01);
      comparar("t1.error", 32'(resp_error_be), 32'd0);
      comparar("t1.cont", cont_fetch_be, 32'd1);
      ciclo();
      comparar("t1.retire_valid", 32'(resp_valid_be), 32'd0);
      comparar("t1.retire_dato", resp_dato_be, 32'h014A1820);

      // Faults and boundaries, back to back
      req_valid = 1'b1; req_dir = 32'd2;          ciclo();
      comparar("t3.mis_err", 32'(resp_error_be), 32'd1);
      comparar("t3.mis_dato", resp_dato_be, 32'd0);
      req_dir = 32'd252;                          ciclo();
      comparar("t3.252_err", 32'(resp_error_be), 32'd0);
      comparar("t3.252_dato", resp_dato_be,
               {patron(252), patron(253), patron(254), patron(255)});
      req_dir = 32'd256;                          ciclo();
      comparar("t3.256_err", 32'(resp_error_be), 32'd1);
      req_dir = 32'hFFFF_FFFC;                    ciclo();
      comparar("t3.wrap_err", 32'(resp_error_be), 32'd1);
      req_dir = 32'd44;                           ciclo();
      comparar("t3.44_dato", resp_dato_be, {patron(44), patron(45), patron(46), patron(47)});
      comparar("t3.cont", cont_fetch_be, 32'd6);
      req_valid = 1'b0;
      ciclo();

      // Backpressure
      fetch(32'd0);
      resp_ready = 1'b0; req_valid = 1'b1; req_dir = 32'd4;
      for (int k = 0; k < 3; k++) begin
         ciclo();
         comparar("t4.hold_dato", resp_dato_be, 32'h014A1820);
         comparar("t4.req_ready", 32'(req_ready_be), 32'd0);
      end
      resp_ready = 1'b1;
      ciclo();
      req_valid = 1'b0;
      comparar("t4.dir4", resp_dato_be, {patron(4), patron(5), patron(6), patron(7)});
      ciclo();

      // Back-to-back with a same-cycle load of address 4
      req_valid = 1'b1; req_dir = 32'd0; ciclo();
      req_dir = 32'd4; carga_en = 1'b1; carga_dir = 32'd4; carga_byte = 8'hFF; ciclo();
      carga_en = 1'b0;
      comparar("t5.old_be", 32'(resp_dato_be[31:24]), 32'h99);
      comparar("t5.old_le", 32'(resp_dato_le[7:0]), 32'h99);
      req_dir = 32'd8; ciclo();
      comparar("t5.dir8_valid", 32'(resp_valid_be), 32'd1);
      req_dir = 32'd4; ciclo();
      req_valid = 1'b0;
      comparar("t5.new_be", 32'(resp_dato_be[31:24]), 32'hFF);
      ciclo();

      // Reset with a stalled response pending
      fetch(32'd0);
      resp_ready = 1'b0; rst = 1'b1;
      ciclo();
      rst = 1'b0;
      comparar("t6.valid", 32'(resp_valid_be), 32'd0);
      comparar("t6.dato", resp_dato_be, 32'd0);
      comparar("t6.cont", cont_fetch_be, 32'd0);
      comparar("t6.req_ready", 32'(req_ready_be), 32'd1);
      resp_ready = 1'b1;
      fetch(32'd0);
      comparar("t6.mem_kept", resp_dato_be, 32'h014A1820);
      ciclo();
      ciclo();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
